clk_switch_ctrl: RTL and testbench
==================================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: CLK cycles SEL is held stable after a change before completion is reported; legal range 1..255.
REQ-002 Parameter LOSS_TIMEOUT, default 64: CLK cycles with no observed edge before a source clock is declared lost; legal range 4..1023.
REQ-003 CLK  input  1  always-on reference clock; all logic is clocked on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 CLK0_TOG  input  1  divide-by-2 toggle generated in the CLK0 domain; asynchronous to CLK.
REQ-006 CLK1_TOG  input  1  divide-by-2 toggle generated in the CLK1 domain; asynchronous to CLK.
REQ-007 REQ_VALID  input  1  switch request valid.
REQ-008 REQ_SEL  input  1  requested source: 0 = CLK0, 1 = CLK1.
REQ-009 REQ_READY  output  1  request accepted when REQ_VALID and REQ_READY are both high.
REQ-010 SEL  output  1  registered select driving the glitchless clock mux SEL pin.
REQ-011 CLK0_OK / CLK1_OK  output  1 each  source activity status.
REQ-012 BUSY  output  1  high whenever the state is not IDLE.
REQ-013 DONE  output  1  one-cycle completion pulse.
REQ-014 ERR  output  1  qualifies DONE: 1 = request rejected.
REQ-015 FAILOVER  output  1  one-cycle pulse on an automatic switch.

Function
REQ-016 Each TOG input passes through a 2-flop synchronizer; a third flop provides XOR edge detection, giving 1 activity event per detected toggle.
REQ-017 Each source has a loss counter: cleared to 0 on an activity event, otherwise incremented, saturating at LOSS_TIMEOUT.
REQ-018 CLKn_OK is 1 when its counter is below LOSS_TIMEOUT; the output is registered.
REQ-019 FSM states: IDLE, CHECK, SETTLE, DONE.
REQ-020 REQ_READY is 1 only in IDLE, and only when no failover is being taken that cycle.
REQ-021 Acceptance at edge N: REQ_SEL is captured as the target, and the FSM enters CHECK at N+1.
REQ-022 CHECK, target equal to SEL: go to DONE with ERR=0; SEL is unchanged.
REQ-023 CHECK, target's OK is 0: go to DONE with ERR=1; SEL is unchanged.
REQ-024 CHECK, otherwise: SEL is loaded with the target on the CHECK->SETTLE edge, and the settle counter is loaded with SETTLE_CYCLES-1.
REQ-025 SETTLE decrements the counter and exits to DONE at 0, so SEL is stable for exactly SETTLE_CYCLES cycles before DONE is entered.
REQ-026 DONE lasts one cycle: DONE=1, ERR valid, then IDLE.
REQ-027 DONE=0 and ERR=0 in all other states.
REQ-028 Accepted-to-DONE latency: 2 cycles for no-op or rejected requests; SETTLE_CYCLES+2 cycles for a switch.
REQ-029 REQ_VALID while BUSY is held off (REQ_READY=0); no request is lost or queued internally.
REQ-030 SEL never changes outside the CHECK->SETTLE transition.
REQ-031 A source loss during SETTLE does not abort the sequence; it is handled from IDLE.

Reset
REQ-032 RESET forces state IDLE, SEL=0, REQ_READY=0 for the asserted duration, BUSY=0, DONE=0, ERR=0, FAILOVER=0.
REQ-033 RESET sets both loss counters to LOSS_TIMEOUT (both OK=0) and clears the synchronizers.
REQ-034 Reset asserted mid-SETTLE abandons the sequence: SEL returns to 0 immediately, and no DONE is issued.
REQ-035 REQ_READY=1 from the first CLK edge after RESET deasserts.

Configuration
REQ-036 Macro CLK_SWITCH_AUTO_FAILOVER_EN, when defined: in IDLE, if the selected source's OK=0 and the other source's OK=1, the FSM takes an internal request to the other source.
REQ-037 Under CLK_SWITCH_AUTO_FAILOVER_EN, the failover request takes priority over REQ_VALID in the same cycle and uses the CHECK/SETTLE/DONE path.
REQ-038 Under CLK_SWITCH_AUTO_FAILOVER_EN, FAILOVER pulses on the CHECK->SETTLE edge, and the completion DONE has ERR=0.
REQ-039 Without CLK_SWITCH_AUTO_FAILOVER_EN: no automatic switching, and FAILOVER is tied to 0.

Verification
REQ-040 Bench scenario: both toggles running, request REQ_SEL=1 accepted at cycle 10 -> SEL=1 from cycle 12; DONE=1, ERR=0 at cycle 28 (SETTLE_CYCLES=16).
REQ-041 Bench scenario: CLK1_TOG held static for 64+ cycles, then REQ_SEL=1 -> DONE with ERR=1 two cycles after acceptance; SEL stays 0.
REQ-042 Bench scenario: SEL=1, then REQ_SEL=1 -> DONE=1, ERR=0 after 2 cycles; SEL unchanged; no FAILOVER.
REQ-043 Bench scenario: REQ_VALID held high during SETTLE -> REQ_READY=0 throughout; the second request is accepted in the cycle after DONE.
REQ-044 Bench scenario: RESET pulsed at SETTLE cycle 5 -> SEL=0, BUSY=0, and no DONE pulse; CLK0_OK=0 until the first CLK0 toggle is seen after reset.
REQ-045 Bench scenario: with CLK_SWITCH_AUTO_FAILOVER_EN, SEL=0, and CLK0_TOG stopped -> CLK0_OK falls 64 cycles after the last detected edge; FAILOVER pulses and SEL=1 within 2 further cycles; DONE follows 16 cycles later.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences the select input of a glitchless clock mux.
// Monitors activity on both source clocks through synchronised divide-by-2
// toggles, accepts switch requests, holds SEL stable for SETTLE_CYCLES
// before reporting completion, and rejects switches to a dead source.
// Optional feature macro: CLK_SWITCH_AUTO_FAILOVER_EN (automatic switch away
// from a lost source while idle).
module clk_switch_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int LOSS_TIMEOUT  = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clk0_tog,
   input  logic clk1_tog,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   output logic sel,
   output logic clk0_ok,
   output logic clk1_ok,
   output logic busy,
   output logic done,
   output logic err,
   output logic failover
);

   localparam int LW = $clog2(LOSS_TIMEOUT + 1);
   localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_TIMEOUT);
   localparam logic [7:0]    SETTLE_LD = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SETTLE, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [2:0]      sync0, sync1;
   logic            ev0, ev1;
   logic [LW-1:0]   loss0, loss1;
   logic            ready_en;
   logic            target;
   logic            tgt_ok;
   logic [7:0]      settle_cnt;
   logic            err_q;
   logic            fo_take;
   logic            accept;
   logic            load_sel;

   // Two synchroniser flops plus one history flop per toggle input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync0 <= '0;
         sync1 <= '0;
      end else begin
         sync0 <= {sync0[1:0], clk0_tog};
         sync1 <= {sync1[1:0], clk1_tog};
      end
   end

   assign ev0 = sync0[2] ^ sync0[1];
   assign ev1 = sync1[2] ^ sync1[1];

   // Loss counters: cleared by activity, otherwise count up and saturate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loss0 <= LOSS_MAX;
         loss1 <= LOSS_MAX;
      end else begin
         if (ev0)                   loss0 <= '0;
         else if (loss0 != LOSS_MAX) loss0 <= loss0 + 1'b1;
         if (ev1)                   loss1 <= '0;
         else if (loss1 != LOSS_MAX) loss1 <= loss1 + 1'b1;
      end
   end

   // Registered activity status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk0_ok <= 1'b0;
         clk1_ok <= 1'b0;
      end else begin
         clk0_ok <= (loss0 < LOSS_MAX);
         clk1_ok <= (loss1 < LOSS_MAX);
      end
   end

`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
   logic fo_flag;
   logic failover_q;

   // Internal request when the selected source died and the other is alive.
   assign fo_take = ready_en && (state == S_IDLE) &&
                    (sel ? (!clk1_ok && clk0_ok) : (!clk0_ok && clk1_ok));

   // Remember that the sequence in flight is a failover; pulse on SEL load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fo_flag    <= 1'b0;
         failover_q <= 1'b0;
      end else begin
         if (state == S_IDLE) fo_flag <= fo_take;
         failover_q <= load_sel && fo_flag;
      end
   end

   assign failover = failover_q;
`else
   assign fo_take  = 1'b0;
   assign failover = 1'b0;
`endif

   assign req_ready = ready_en && (state == S_IDLE) && !fo_take;
   assign accept    = req_valid && req_ready;
   assign tgt_ok    = target ? clk1_ok : clk0_ok;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and SEL load strobe.
   always_comb begin
      state_nxt = state;
      load_sel  = 1'b0;
      case (state)
         S_IDLE:   if (fo_take || accept) state_nxt = S_CHECK;
         S_CHECK: begin
            if (target == sel)  state_nxt = S_DONE;
            else if (!tgt_ok)   state_nxt = S_DONE;
            else begin
               state_nxt = S_SETTLE;
               load_sel  = 1'b1;
            end
         end
         S_SETTLE: if (settle_cnt == 8'd0) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Request capture, SEL register, settle countdown and reject flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_en   <= 1'b0;
         target     <= 1'b0;
         sel        <= 1'b0;
         settle_cnt <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (state == S_IDLE) begin
            if (fo_take)     target <= ~sel;
            else if (accept) target <= req_sel;
         end
         if (state == S_CHECK) err_q <= (target != sel) && !tgt_ok;
         if (load_sel) begin
            sel        <= target;
            settle_cnt <= SETTLE_LD;
         end else if (state == S_SETTLE && settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
         end
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
   assign err  = done && err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed requests push their expected completion
// (err, sel, cycle) into a queue; a monitor pops and compares on every DONE.
module tb_clk_switch_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clk0_tog = 1'b0, clk1_tog = 1'b0;
   logic req_valid = 1'b0, req_sel = 1'b0;
   logic req_ready, sel, clk0_ok, clk1_ok, busy, done, err, failover;
   bit   run0 = 1'b1, run1 = 1'b1;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic err;
      logic sel;
      int   cyc;
   } exp_t;
   exp_t sb[$];

   clk_switch_ctrl #(.SETTLE_CYCLES(16), .LOSS_TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .clk0_tog(clk0_tog), .clk1_tog(clk1_tog),
      .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
      .sel(sel), .clk0_ok(clk0_ok), .clk1_ok(clk1_ok), .busy(busy),
      .done(done), .err(err), .failover(failover)
   );

   initial forever #5 clk = ~clk;
   initial forever begin #13; if (run0) clk0_tog = ~clk0_tog; end
   initial forever begin #17; if (run1) clk1_tog = ~clk1_tog; end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: DONE pulses against the scoreboard, plus per-cycle invariants.
   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done cyc=%0d err=%b sel=%b (no request pending)", cyc, err, sel);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (err !== e.err || sel !== e.sel || cyc != e.cyc) begin
               failures++;
               $display("FAIL done_cmp got err=%b sel=%b cyc=%0d expected err=%b sel=%b cyc=%0d",
                        err, sel, cyc, e.err, e.sel, e.cyc);
            end
         end
      end
      checks++;
      if (busy && req_ready) begin
         failures++;
         $display("FAIL ready_while_busy cyc=%0d req_ready=1 expected 0", cyc);
      end
`ifndef CLK_SWITCH_AUTO_FAILOVER_EN
      checks++;
      if (failover !== 1'b0) begin
         failures++;
         $display("FAIL failover_tied cyc=%0d got %b expected 0", cyc, failover);
      end
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents a request at a negedge; acc is the cycle it was presented in
   // with ready high. DONE is expected lat cycles later.
   task automatic issue(input logic s, input logic e_err, input logic e_sel,
                        input int lat, input bit push, output int acc);
      bit got;
      got = 1'b0;
      acc = -1;
      req_sel = s;
      req_valid = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         if (req_ready) begin
            got = 1'b1;
            acc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL accept_timeout req_sel=%b got no ready in 100 cycles expected acceptance", s);
      end else if (push) begin
         sb.push_back('{err: e_err, sel: e_sel, cyc: acc + lat});
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      int a, a1, a2, f;
      bit seen;

      // Reset state.
      cycles(3);
      chk("rst_ready", req_ready, 0);
      chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_failover", failover, 0);
      chk("rst_ok0", clk0_ok, 0);
      chk("rst_ok1", clk1_ok, 0);
      reset = 1'b0;
      cycles(1);
      chk("ready_after_rst", req_ready, 1);
      cycles(20);
      chk("ok0_up", clk0_ok, 1);
      chk("ok1_up", clk1_ok, 1);

      // Switch to CLK1: SEL changes two cycles after presentation, DONE at +18.
      issue(1'b1, 1'b0, 1'b1, 18, 1'b1, a);
      chk("sel_in_check", sel, 0);
      cycles(1);
      chk("sel_in_settle", sel, 1);
      chk("busy_in_settle", busy, 1);
      cycles(20);

      // No-op request to the already selected source.
      issue(1'b1, 1'b0, 1'b1, 2, 1'b1, a);
      cycles(5);
      chk("noop_sel", sel, 1);

      // Back-to-back: second request held during SETTLE, accepted after DONE.
      issue(1'b0, 1'b0, 1'b0, 18, 1'b1, a1);
      issue(1'b1, 1'b0, 1'b1, 18, 1'b1, a2);
      chk("held_accept_cycle", a2, a1 + 19);
      cycles(20);
      issue(1'b0, 1'b0, 1'b0, 18, 1'b1, a);
      cycles(20);
      chk("back_to_clk0", sel, 0);

      // Dead CLK1: request rejected after two cycles, SEL stays 0.
      run1 = 1'b0;
      cycles(80);
      chk("ok1_lost", clk1_ok, 0);
      issue(1'b1, 1'b1, 1'b0, 2, 1'b1, a);
      cycles(5);
      chk("reject_sel", sel, 0);

      // Reset during SETTLE cycle 5; toggles parked low so none is seen after.
      run1 = 1'b1;
      cycles(20);
      chk("ok1_back", clk1_ok, 1);
      run0 = 1'b0;
      run1 = 1'b0;
      clk0_tog = 1'b0;
      clk1_tog = 1'b0;
      issue(1'b1, 1'b0, 1'b1, 18, 1'b0, a);
      cycles(5);
      chk("pre_rst_sel", sel, 1);
      reset = 1'b1;
      #1;
      chk("midrst_sel", sel, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      cycles(2);
      chk("midrst_ready", req_ready, 0);
      reset = 1'b0;
      cycles(1);
      chk("ready_after_midrst", req_ready, 1);
      cycles(20);
      chk("ok0_quiet", clk0_ok, 0);
      chk("sel_after_midrst", sel, 0);
      run0 = 1'b1;
      cycles(20);
      chk("ok0_resumed", clk0_ok, 1);
      run1 = 1'b1;
      cycles(20);

`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
      // Stop CLK0 while selected: failover to CLK1 through the normal path.
      run0 = 1'b0;
      seen = 1'b0;
      f = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (!clk0_ok) begin
            seen = 1'b1;
            f = cyc;
         end else begin
            @(negedge clk);
         end
      end
      chk("ok0_fell", seen, 1);
      if (seen) sb.push_back('{err: 1'b0, sel: 1'b1, cyc: f + 18});
      cycles(2);
      chk("failover_pulse", failover, 1);
      chk("failover_sel", sel, 1);
      cycles(20);
      run0 = 1'b1;
`endif

      // Drain the scoreboard.
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
